multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  FSM controller for the multi-cycle RV32I datapath (shared ALU, single unified memory, IR/OldPC latches).
//  Adds a memory wait handshake, all six branch types, JALR/LUI, and an optional 4-bit ALU code set.
//  Sits between the instruction register fields and the datapath mux/enable controls.
// PARAMETERS
//  ALUCTRL_W     3  ALUControl width; 3 = add/sub/and/or/slt only, 4 = full RV32I ALU set
//  EN_EXT_BRANCH 1  1 = BNE/BLT/BGE/BLTU/BGEU legal; 0 = BEQ only
//  EN_MEM_WAIT   0  1 = memory states stall on mem_ready; 0 = mem_ready ignored (1-cycle memory)
// PORTS
//  clk        in  1  clock, rising edge
//  reset      in  1  synchronous, active-high
//  op         in  7  IR[6:0]
//  funct3     in  3  IR[14:12]
//  funct7     in  1  IR[30]
//  zero, lt, ltu in 1 each  ALU flags: result==0, signed A<B, unsigned A<B
//  mem_ready  in  1  memory access complete this cycle
//  PCWrite, IRWrite, MemWrite, RegWrite  out 1 each  write enables
//  AdrSrc     out 1  0=PC, 1=ALUOut
//  ResultSrc  out 2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out 2  00 PC, 01 OldPC, 10 rs1, 11 zero
//  ALUSrcB    out 2  00 rs2, 01 imm, 10 const 4
//  ImmSrc     out 3  000 I, 001 S, 010 B, 011 J, 100 U
//  ALUControl out ALUCTRL_W
//  illegal    out 1  one-cycle pulse in DECODE on unsupported encoding
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI.
//  FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 -> DECODE.
//  DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target) -> lw/sw:MEMADR, R:EXECR, I-ALU:EXECI,
//   B:BRANCH, jal:JAL, jalr:JALR, lui:LUI; illegal -> illegal=1, FETCH, no write enable.
//  MEMADR: rs1+imm -> lw:MEMREAD, sw:MEMWRITE. MEMREAD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite.
//  MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH. EXECR/EXECI: rs1 op rs2/imm -> ALUWB (ResultSrc=00, RegWrite).
//  BRANCH: rs1 - rs2, ResultSrc=00, PCWrite=take -> FETCH. JAL: OldPC+4, PCWrite (ALUOut) -> ALUWB.
//  JALR: rs1+imm, ResultSrc=10, PCWrite -> state writes OldPC+4 via JAL path (JALR -> JAL-link ALUWB).
//  LUI: zero+U-imm -> ALUWB.
//  Cycles (EN_MEM_WAIT=0): lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 4.
//  take: f3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 illegal; non-000 illegal if !EN_EXT_BRANCH.
//  ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
//   ALUCTRL_W=3 uses low 3 bits; xor/sltu/shifts then flagged illegal in DECODE.
//   SUB when R-type & funct3=000 & funct7; SRA when funct3=101 & funct7 (R and I).
//  EN_MEM_WAIT=1: FETCH gates IRWrite/PCWrite with mem_ready and holds; MEMREAD holds until mem_ready;
//   MEMWRITE holds MemWrite=1 until mem_ready; mem_ready outside memory states ignored.
//  Reset: while reset=1 all write enables and illegal are 0; next state FETCH. Reset mid-instruction
//   aborts it; no partial write occurs in the reset cycle. Other outputs follow FETCH decode.
//  Outputs purely combinational from state + IR fields + flags; only state is registered.
// STRUCTURE
//  Package riscv_ctrl_pkg: state enum, opcode constants, ALU code constants, ImmSrc/mux encodings.
//  Sub-module alu_decoder_ext (ALUOp, funct3, funct7, op[5] -> ALUControl, alu_illegal), parametrised on ALUCTRL_W.
// TESTING
//  lw x1 (op 0000011), EN_MEM_WAIT=0 -> states F,D,MEMADR,MEMREAD,MEMWB; RegWrite only cycle 5, ResultSrc=01.
//  EN_MEM_WAIT=1, sw, mem_ready low 3 cycles -> MemWrite high 4 cycles, exits to FETCH cycle after ready.
//  bne with zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0; EN_EXT_BRANCH=0 -> illegal pulse, FETCH.
//  R-type sra (f3 101, funct7=1), ALUCTRL_W=4 -> ALUControl=1001; ALUCTRL_W=3 -> illegal=1, no RegWrite.
//  op 7'b1111111 -> illegal=1 for exactly one cycle in DECODE, back to FETCH, all enables 0.
//  reset asserted in MEMWRITE -> MemWrite=0 that cycle, FETCH next; jalr -> 5 cycles, PCWrite in JALR.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes, ALU codes and mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder_ext.sv
// ALU control decoder: maps ALUOp and funct fields to an ALU code, flagging codes the narrow ALU cannot run.
module alu_decoder_ext
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 alu_illegal
);
  localparam bit NARROW = (ALUCTRL_W < 4);

  logic [3:0] funct_code;

  always_comb begin
    funct_code = ALU_ADD;
    case (funct3)
      3'b000:  funct_code = (op5 && funct7) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_code = ALU_SLL;
      3'b010:  funct_code = ALU_SLT;
      3'b011:  funct_code = ALU_SLTU;
      3'b100:  funct_code = ALU_XOR;
      3'b101:  funct_code = funct7 ? ALU_SRA : ALU_SRL;
      3'b110:  funct_code = ALU_OR;
      default: funct_code = ALU_AND;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD[ALUCTRL_W-1:0];
      ALUOP_SUB: alu_control = ALU_SUB[ALUCTRL_W-1:0];
      default:   alu_control = funct_code[ALUCTRL_W-1:0];
    endcase
  end

  // Judged on the funct fields alone so DECODE can reject an R/I op before ALUOp selects it.
  assign alu_illegal = NARROW && (funct_code[3] || (funct_code == ALU_XOR) ||
                                  (funct_code == ALU_SLTU) || (funct_code == ALU_SLL));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM driving the shared-ALU datapath muxes and write enables.
// state | meaning: FETCH ifetch, PC+4 | DECODE target calc, dispatch | MEMADR/MEMREAD/MEMWB/MEMWRITE load-store
// EXECR/EXECI alu op | ALUWB reg write | BRANCH compare | JAL link+PC | JALR rs1+imm | LUI upper imm
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit EN_EXT_BRANCH = 1'b1,
  parameter bit EN_MEM_WAIT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal
);
  state_t     state, state_next, cur, dec_next;
  logic [1:0] alu_op;
  logic       alu_illegal, take, branch_ok, ready, dec_illegal;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // While reset is held the muxes present the FETCH decode.
  assign cur    = reset ? S_FETCH : state;
  assign ready  = !EN_MEM_WAIT || mem_ready;
  assign ImmSrc = imm_src_for(op);

  alu_decoder_ext #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .op5         (op[5]),
    .alu_control (ALUControl),
    .alu_illegal (alu_illegal)
  );

  always_comb begin
    take      = 1'b0;
    branch_ok = 1'b1;
    case (funct3)
      3'b000:  take = zero;
      3'b001:  take = !zero;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      3'b110:  take = ltu;
      3'b111:  take = !ltu;
      default: branch_ok = 1'b0;
    endcase
    if (!EN_EXT_BRANCH && (funct3 != 3'b000)) branch_ok = 1'b0;
  end

  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: dec_next = S_MEMADR;
      OP_R:      if (alu_illegal) dec_illegal = 1'b1; else dec_next = S_EXECR;
      OP_I:      if (alu_illegal) dec_illegal = 1'b1; else dec_next = S_EXECI;
      OP_BRANCH: if (branch_ok) dec_next = S_BRANCH; else dec_illegal = 1'b1;
      OP_JAL:    dec_next = S_JAL;
      OP_JALR:   dec_next = S_JALR;
      OP_LUI:    dec_next = S_LUI;
      default:   dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        IRWrite    = ready;
        PCWrite    = ready;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        state_next = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        illegal    = dec_illegal;
        state_next = dec_next;
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        state_next = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        PCWrite = take;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      // PC takes rs1+imm straight from the ALU; JAL then links OldPC+4 and rewrites the same target from ALUOut.
      S_JALR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        PCWrite    = 1'b1;
        state_next = S_JAL;
      end
      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two configurations driven from per-instruction step lists built from the ISA rules.
module tb_multicycle_control_unit;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011,
                         T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_BAD = 7'b1111111;

  typedef struct packed {
    logic pcw, irw, mw, rw, adr, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
  } outs_t;

  typedef enum int {K_FETCH, K_DECODE, K_ADDR, K_READ, K_LOADWB, K_WRITE, K_EXR, K_EXI,
                    K_WB, K_BR, K_LINK, K_JALR, K_LUI} step_t;

  typedef struct {
    step_t s;
    logic  mrdy, rst, z, lt, ltu;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_s [2];
  logic [6:0] op_s  [2];
  logic [2:0] f3_s  [2];
  logic       f7_s [2], z_s [2], lt_s [2], ltu_s [2], mr_s [2];

  logic pcw_a, irw_a, mw_a, rw_a, adr_a, ill_a, pcw_b, irw_b, mw_b, rw_b, adr_b, ill_b;
  logic [1:0] res_a, sa_a, sb_a, res_b, sa_b, sb_b;
  logic [2:0] imm_a, imm_b, alu_b;
  logic [3:0] alu_a;
  outs_t got_a, got_b, g, exp_cur;

  int    checks = 0, failures = 0, exp_k = 0, exp_step = 0;
  logic  exp_valid = 1'b0;
  ent_t  seq [$];
  outs_t obs [$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTRL_W(4), .EN_EXT_BRANCH(1'b1), .EN_MEM_WAIT(1'b0)) dut_a (
    .clk(clk), .reset(rst_s[0]), .op(op_s[0]), .funct3(f3_s[0]), .funct7(f7_s[0]),
    .zero(z_s[0]), .lt(lt_s[0]), .ltu(ltu_s[0]), .mem_ready(mr_s[0]),
    .PCWrite(pcw_a), .IRWrite(irw_a), .MemWrite(mw_a), .RegWrite(rw_a), .AdrSrc(adr_a),
    .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a), .ALUControl(alu_a),
    .illegal(ill_a));

  multicycle_control_unit #(.ALUCTRL_W(3), .EN_EXT_BRANCH(1'b0), .EN_MEM_WAIT(1'b1)) dut_b (
    .clk(clk), .reset(rst_s[1]), .op(op_s[1]), .funct3(f3_s[1]), .funct7(f7_s[1]),
    .zero(z_s[1]), .lt(lt_s[1]), .ltu(ltu_s[1]), .mem_ready(mr_s[1]),
    .PCWrite(pcw_b), .IRWrite(irw_b), .MemWrite(mw_b), .RegWrite(rw_b), .AdrSrc(adr_b),
    .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b), .ALUControl(alu_b),
    .illegal(ill_b));

  assign got_a = {pcw_a, irw_a, mw_a, rw_a, adr_a, ill_a, res_a, sa_a, sb_a, imm_a, alu_a};
  assign got_b = {pcw_b, irw_b, mw_b, rw_b, adr_b, ill_b, res_b, sa_b, sb_b, imm_b, 1'b0, alu_b};

  // Instance 0: full ALU, all branches, 1-cycle memory. Instance 1: narrow ALU, BEQ only, wait handshake.
  function automatic int  cfg_w   (input int k); return (k == 0) ? 4 : 3; endfunction
  function automatic bit  cfg_ext (input int k); return k == 0;            endfunction
  function automatic bit  cfg_wait(input int k); return k == 1;            endfunction
  function automatic logic rbit(); return 1'($urandom_range(0, 1));        endfunction

  function automatic logic [3:0] funct_code(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'd0 && op == T_R && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd9;
    return tbl[f3];
  endfunction

  function automatic bit legal(input int k, input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] c;
    c = funct_code(op, f3, f7);
    case (op)
      T_LOAD, T_STORE, T_JAL, T_JALR, T_LUI: return 1'b1;
      T_R, T_I: return (cfg_w(k) == 4) || (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5});
      T_BR:     return (f3 != 3'd2) && (f3 != 3'd3) && (cfg_ext(k) || f3 == 3'd0);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == T_STORE) return 3'd1;
    if (op == T_BR)    return 3'd2;
    if (op == T_JAL)   return 3'd3;
    if (op == T_LUI)   return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic take_of(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    logic cond;
    cond = f3[2] ? (f3[1] ? ltu : lt) : z;
    return cond ^ f3[0];
  endfunction

  function automatic outs_t step_out(input int k, input step_t s_in, input logic [6:0] op, input logic [2:0] f3,
                                     input logic f7, input ent_t e);
    outs_t o;
    step_t s;
    o = '0;
    s = e.rst ? K_FETCH : s_in;
    o.imm = imm_of(op);
    case (s)
      K_FETCH:  begin o.irw = cfg_wait(k) ? e.mrdy : 1'b1; o.pcw = o.irw; o.sb = 2'd2; o.res = 2'd2; end
      K_DECODE: begin o.sa = 2'd1; o.sb = 2'd1; o.ill = !legal(k, op, f3, f7); end
      K_ADDR:   begin o.sa = 2'd2; o.sb = 2'd1; end
      K_READ:   o.adr = 1'b1;
      K_LOADWB: begin o.res = 2'd1; o.rw = 1'b1; end
      K_WRITE:  begin o.adr = 1'b1; o.mw = 1'b1; end
      K_EXR:    begin o.sa = 2'd2; o.alu = funct_code(op, f3, f7); end
      K_EXI:    begin o.sa = 2'd2; o.sb = 2'd1; o.alu = funct_code(op, f3, f7); end
      K_WB:     o.rw = 1'b1;
      K_BR:     begin o.sa = 2'd2; o.alu = 4'd1; o.pcw = take_of(f3, e.z, e.lt, e.ltu); end
      K_LINK:   begin o.sa = 2'd1; o.sb = 2'd2; o.pcw = 1'b1; end
      K_JALR:   begin o.sa = 2'd2; o.sb = 2'd1; o.res = 2'd2; o.pcw = 1'b1; end
      K_LUI:    begin o.sa = 2'd3; o.sb = 2'd1; end
      default:  o = '0;
    endcase
    if (cfg_w(k) == 3) o.alu[3] = 1'b0;
    if (e.rst) begin o.pcw = 0; o.irw = 0; o.mw = 0; o.rw = 0; o.ill = 0; end
    return o;
  endfunction

  function automatic void push(input step_t s, input logic mrdy, input logic rst);
    ent_t e;
    e.s = s; e.mrdy = mrdy; e.rst = rst; e.z = rbit(); e.lt = rbit(); e.ltu = rbit();
    seq.push_back(e);
  endfunction

  function automatic void push_mem(input int k, input step_t s, input int w);
    if (cfg_wait(k)) begin
      repeat (w) push(s, 1'b0, 1'b0);
      push(s, 1'b1, 1'b0);
    end else push(s, rbit(), 1'b0);
  endfunction

  function automatic void build_seq(input int k, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                    input int wf, input int wm);
    seq.delete();
    push_mem(k, K_FETCH, wf);
    push(K_DECODE, rbit(), 1'b0);
    if (legal(k, op, f3, f7)) begin
      case (op)
        T_LOAD:  begin push(K_ADDR, rbit(), 0); push_mem(k, K_READ, wm); push(K_LOADWB, rbit(), 0); end
        T_STORE: begin push(K_ADDR, rbit(), 0); push_mem(k, K_WRITE, wm); end
        T_R:     begin push(K_EXR, rbit(), 0); push(K_WB, rbit(), 0); end
        T_I:     begin push(K_EXI, rbit(), 0); push(K_WB, rbit(), 0); end
        T_BR:    push(K_BR, rbit(), 0);
        T_JAL:   begin push(K_LINK, rbit(), 0); push(K_WB, rbit(), 0); end
        T_JALR:  begin push(K_JALR, rbit(), 0); push(K_LINK, rbit(), 0); push(K_WB, rbit(), 0); end
        default: begin push(K_LUI, rbit(), 0); push(K_WB, rbit(), 0); end
      endcase
    end
  endfunction

  task automatic run_seq(input int k, input logic [6:0] op, input logic [2:0] f3, input logic f7);
    obs.delete();
    foreach (seq[i]) begin
      @(posedge clk); #1;
      rst_s[k] = seq[i].rst; rst_s[1-k] = 1'b1;
      op_s[k] = op; f3_s[k] = f3; f7_s[k] = f7;
      z_s[k] = seq[i].z; lt_s[k] = seq[i].lt; ltu_s[k] = seq[i].ltu; mr_s[k] = seq[i].mrdy;
      exp_cur = step_out(k, seq[i].s, op, f3, f7, seq[i]);
      exp_step = int'(seq[i].s); exp_k = k; exp_valid = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  task automatic check_lit(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic do_reset(input int k);
    seq.delete();
    push(K_FETCH, rbit(), 1'b1);
    run_seq(k, 7'($urandom), 3'($urandom), rbit());
  endtask

  task automatic set_z(input int idx, input logic z);
    ent_t e;
    e = seq[idx]; e.z = z; seq[idx] = e;
  endtask

  task automatic random_instrs(input int k, input int n);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0: op = T_LOAD;  1: op = T_STORE; 2: op = T_R;   3: op = T_I;  4: op = T_BR;
        5: op = T_JAL;   6: op = T_JALR;  7: op = T_LUI; 8: op = T_BAD;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      f7 = rbit();
      build_seq(k, op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3));
      run_seq(k, op, f3, f7);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      g = (exp_k == 0) ? got_a : got_b;
      obs.push_back(g);
      checks++;
      if (g !== exp_cur) begin
        failures++;
        $display("FAIL cycle inst=%0d step=%0d got=%h required=%h", exp_k, exp_step, g, exp_cur);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; op_s[i] = '0; f3_s[i] = '0; f7_s[i] = 0;
      z_s[i] = 0; lt_s[i] = 0; ltu_s[i] = 0; mr_s[i] = 0;
    end

    do_reset(0);
    build_seq(0, T_LOAD, 3'd2, 1'b0, 0, 0);
    check_lit("lw_len", seq.size(), 5);
    run_seq(0, T_LOAD, 3'd2, 1'b0);
    check_lit("lw_rw_c4", obs[3].rw, 0);
    check_lit("lw_rw_c5", obs[4].rw, 1);
    check_lit("lw_res_c5", obs[4].res, 1);

    build_seq(0, T_BR, 3'd1, 1'b0, 0, 0); set_z(2, 1'b0);
    run_seq(0, T_BR, 3'd1, 1'b0);
    check_lit("bne_taken", obs[2].pcw, 1);
    build_seq(0, T_BR, 3'd1, 1'b0, 0, 0); set_z(2, 1'b1);
    run_seq(0, T_BR, 3'd1, 1'b0);
    check_lit("bne_not_taken", obs[2].pcw, 0);

    build_seq(0, T_R, 3'd5, 1'b1, 0, 0);
    run_seq(0, T_R, 3'd5, 1'b1);
    check_lit("sra_code", obs[2].alu, 9);

    build_seq(0, T_BAD, 3'd0, 1'b0, 0, 0);
    check_lit("bad_len", seq.size(), 2);
    run_seq(0, T_BAD, 3'd0, 1'b0);
    check_lit("bad_ill_decode", obs[1].ill, 1);
    check_lit("bad_ill_fetch", obs[0].ill, 0);

    build_seq(0, T_JALR, 3'd0, 1'b0, 0, 0);
    check_lit("jalr_len", seq.size(), 5);
    run_seq(0, T_JALR, 3'd0, 1'b0);
    check_lit("jalr_pcw", obs[2].pcw, 1);

    build_seq(0, T_STORE, 3'd2, 1'b0, 0, 0);
    begin ent_t e; e = seq[3]; e.rst = 1'b1; seq[3] = e; end
    run_seq(0, T_STORE, 3'd2, 1'b0);
    check_lit("sw_reset_mw", obs[3].mw, 0);

    random_instrs(0, 150);

    do_reset(1);
    build_seq(1, T_STORE, 3'd2, 1'b0, 0, 3);
    check_lit("sw_wait_len", seq.size(), 7);
    run_seq(1, T_STORE, 3'd2, 1'b0);
    n = 0;
    foreach (obs[i]) n += int'(obs[i].mw);
    check_lit("sw_wait_mw_cycles", n, 4);

    build_seq(1, T_BR, 3'd1, 1'b0, 0, 0);
    run_seq(1, T_BR, 3'd1, 1'b0);
    check_lit("bne_narrow_ill", obs[1].ill, 1);

    build_seq(1, T_R, 3'd5, 1'b1, 0, 0);
    run_seq(1, T_R, 3'd5, 1'b1);
    check_lit("sra_narrow_ill", obs[1].ill, 1);
    n = 0;
    foreach (obs[i]) n += int'(obs[i].rw);
    check_lit("sra_narrow_rw", n, 0);

    random_instrs(1, 150);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
